// File: rtl/jt89_ctrl.sv
// jt89_ctrl: SN76489 CPU register decode, busy/ready handshake
// and channel clock prescaler for the JT89 PSG.
module jt89_ctrl #(
  parameter int DIV      = 16,
  parameter int BUSY_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic       clken,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_clr
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [7:0]    BLEN = 8'(BUSY_LEN);

  logic [9:0]    tone_q [3];
  logic [9:0]    tone_d [3];
  logic [3:0]    vol_q  [4];
  logic [3:0]    vol_d  [4];
  logic [2:0]    ctrl3_q, ctrl3_d;
  logic [2:0]    addr_q, addr_d;
  logic          clr_q, clr_d;
  logic          act_q, act_d;
  logic [7:0]    busy_q, busy_d;
  logic          rdy_q, rdy_d;
  logic [PW-1:0] pre_q, pre_d;

  logic          wr;
  logic [2:0]    tgt;

  // Edge detect: a held strobe yields one write
  assign act_d = ~cs_n & ~wr_n;
  assign wr    = act_d & ~act_q;
  assign tgt   = din[7] ? din[6:4] : addr_q;

  always_comb begin
    tone_d  = tone_q;
    vol_d   = vol_q;
    ctrl3_d = ctrl3_q;
    addr_d  = addr_q;
    clr_d   = 1'b0;
    if (wr) begin
      if (din[7]) addr_d = din[6:4];
      if (tgt[0]) begin
        vol_d[tgt[2:1]] = din[3:0];
      end else begin
        unique case (tgt[2:1])
          2'd3: begin
            ctrl3_d = din[2:0];
            clr_d   = 1'b1;
          end
          default: begin
            if (din[7]) tone_d[tgt[2:1]][3:0] = din[3:0];
            else        tone_d[tgt[2:1]][9:4] = din[5:0];
          end
        endcase
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    rdy_d  = (busy_q == 8'd0);
    if (wr) begin
      busy_d = BLEN;
      rdy_d  = 1'b0;
    end else if (cen && busy_q != 8'd0) begin
      busy_d = busy_q - 8'd1;
    end
  end

  always_comb begin
    pre_d = pre_q;
    if (cen) pre_d = (pre_q == PMAX) ? '0 : pre_q + PONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_q  <= '{default: '0};
      vol_q   <= '{default: 4'hF};
      ctrl3_q <= '0;
      addr_q  <= '0;
      clr_q   <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= '0;
      rdy_q   <= 1'b1;
      pre_q   <= '0;
    end else begin
      tone_q  <= tone_d;
      vol_q   <= vol_d;
      ctrl3_q <= ctrl3_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      pre_q   <= pre_d;
    end
  end

  assign ready     = rdy_q;
  assign clken     = cen & (pre_q == PMAX);
  assign tone0     = tone_q[0];
  assign tone1     = tone_q[1];
  assign tone2     = tone_q[2];
  assign vol0      = vol_q[0];
  assign vol1      = vol_q[1];
  assign vol2      = vol_q[2];
  assign vol3      = vol_q[3];
  assign ctrl3     = ctrl3_q;
  assign noise_clr = clr_q;

endmodule

// File: tb/tb_jt89_ctrl.sv
// tb_jt89_ctrl: random and directed stimulus for jt89_ctrl
// against a behavioural model of the PSG register map.
module tb_jt89_ctrl;

  localparam int DIV = 16;
  localparam int BL  = 32;

  logic       clk = 1'b0;
  logic       rst, cen, cs_n, wr_n;
  logic [7:0] din;
  logic       ready, clken, noise_clr;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;

  jt89_ctrl #(.DIV(DIV), .BUSY_LEN(BL)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
    .din(din), .ready(ready), .clken(clken),
    .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .ctrl3(ctrl3), .noise_clr(noise_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] m_tone [3];
  logic [3:0] m_vol  [4];
  logic [2:0] m_ctrl, m_addr;
  logic       m_clr, m_act, m_ready, m_wrote;
  int         m_ncen, m_cens;
  logic       s_ready, s_clken, s_clr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = '0;
    for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
    m_ctrl = '0; m_addr = '0; m_clr = 0; m_act = 0;
    m_ready = 1; m_wrote = 0; m_ncen = 0; m_cens = 0;
  endtask

  task automatic model_edge(input logic c, input logic cs, input logic w,
                            input logic [7:0] d);
    logic act, wr;
    logic [2:0] a;
    int ch;
    act = !cs && !w;
    wr = act && !m_act;
    m_act = act;
    m_clr = 0;
    if (wr) begin
      a = d[7] ? d[6:4] : m_addr;
      if (d[7]) m_addr = d[6:4];
      ch = int'(a[2:1]);
      if (a[0]) m_vol[ch] = d[3:0];
      else if (ch == 3) begin m_ctrl = d[2:0]; m_clr = 1; end
      else if (d[7]) m_tone[ch][3:0] = d[3:0];
      else m_tone[ch][9:4] = d[5:0];
      m_ready = 0; m_wrote = 1; m_ncen = 0;
    end else begin
      m_ready = !m_wrote || (m_ncen >= BL);
      if (c) m_ncen++;
    end
    if (c) m_cens++;
  endtask

  task automatic step(input logic c, input logic cs, input logic w,
                      input logic [7:0] d);
    cen = c; cs_n = cs; wr_n = w; din = d;
    @(negedge clk);
    s_ready = ready; s_clken = clken; s_clr = noise_clr;
    check("tone0", tone0, m_tone[0]);
    check("tone1", tone1, m_tone[1]);
    check("tone2", tone2, m_tone[2]);
    check("vol0", vol0, m_vol[0]);
    check("vol1", vol1, m_vol[1]);
    check("vol2", vol2, m_vol[2]);
    check("vol3", vol3, m_vol[3]);
    check("ctrl3", ctrl3, m_ctrl);
    check("nclr", noise_clr, m_clr);
    check("ready", ready, m_ready);
    check("clken", clken, c && ((m_cens % DIV) == DIV - 1));
    @(posedge clk);
    model_edge(c, cs, w, d);
    #1;
  endtask

  task automatic idle(input logic c);
    step(c, 1'b1, 1'b1, 8'($urandom));
  endtask

  task automatic wbyte(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 300) begin idle(1'b1); k++; end
    check("rdy_timeout", ready, 1);
  endtask

  task automatic count_busy(input string tag, input int exp);
    int low = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1'b1);
      if (s_ready) break;
      low++;
    end
    check(tag, low, exp);
  endtask

  task automatic check_reset_vals();
    check("rst_tone0", tone0, 0);
    check("rst_tone1", tone1, 0);
    check("rst_tone2", tone2, 0);
    check("rst_vol0", vol0, 4'hF);
    check("rst_vol1", vol1, 4'hF);
    check("rst_vol2", vol2, 4'hF);
    check("rst_vol3", vol3, 4'hF);
    check("rst_ctrl3", ctrl3, 0);
    check("rst_nclr", noise_clr, 0);
    check("rst_clken", clken, 0);
    check("rst_ready", ready, 1);
  endtask

  initial begin
    int last, npulse, low;
    logic prev;
    rst = 1; cen = 0; cs_n = 1; wr_n = 1; din = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 0;

    // Tone write: latch + data
    wbyte(8'h8E); idle(1'b1);
    wbyte(8'h0F); idle(1'b1);
    check("tone0_fe", tone0, 10'h0FE);
    wait_ready();

    // Held strobe: one write, one busy load
    wbyte(8'h9A);
    low = 0;
    for (int i = 0; i < 9; i++) begin
      wbyte(8'h9A);
      if (!s_ready) low++;
    end
    for (int i = 0; i < 100; i++) begin
      idle(1'b1);
      if (s_ready) break;
      low++;
    end
    check("held_busy", low, 33);
    check("held_vol0", vol0, 4'hA);

    // Noise writes
    wbyte(8'hE5);
    idle(1'b1);
    check("nclr_1", s_clr, 1);
    check("ctrl3_5", ctrl3, 3'b101);
    idle(1'b1);
    check("nclr_1off", s_clr, 0);
    wbyte(8'h02);
    idle(1'b1);
    check("nclr_2", s_clr, 1);
    check("ctrl3_2", ctrl3, 3'b010);
    idle(1'b1);
    check("nclr_2off", s_clr, 0);
    wait_ready();

    // Ready timing
    wbyte(8'hB3);
    count_busy("busy_single", 33);
    wait_ready();
    wbyte(8'hD7);
    for (int i = 0; i < 19; i++) idle(1'b1);
    wbyte(8'hC1);
    count_busy("busy_reload", 33);

    // Prescaler with cen every 2nd clk
    last = -1; npulse = 0; prev = 0;
    for (int i = 0; i < 240; i++) begin
      if (i % 7 == 3) step(i % 2 == 0, 1'b0, 1'b0, 8'($urandom));
      else idle(i % 2 == 0);
      if (s_clken) begin
        check("clken_width", prev, 0);
        if (last >= 0) check("clken_period", i - last, 32);
        last = i;
        npulse++;
      end
      prev = s_clken;
    end
    check("clken_pulses", npulse >= 6, 1);

    // Random traffic: dense then sparse writes
    for (int i = 0; i < 1500; i++)
      step($urandom % 3 != 0, $urandom % 3 == 0, $urandom % 2 == 0,
           8'($urandom));
    for (int i = 0; i < 1500; i++)
      step($urandom % 4 != 0, $urandom % 12 != 0, $urandom % 4 == 0,
           8'($urandom));

    // Async reset mid-cycle aborts a pending write
    cen = 1; cs_n = 0; wr_n = 0; din = 8'h83;
    #2 rst = 1;
    #1 check_reset_vals();
    cs_n = 1; wr_n = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 40; i++) idle(1'b1);
    check("post_rst_tone0", tone0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
